// File: rtl/inst_enc.sv
// -----------------------------------------------------------------------------
// inst_enc -- RV32I instruction encoder.
//
// Accepts one encode request at a time (format, opcode, function fields,
// register indices, byte-valued immediate) and emits the encoded 32-bit
// instruction word(s) through a valid/ready output port. The LI pseudo
// expands into ADDI, or LUI (+ ADDI when the low 12 bits are non-zero).
// Requests whose immediate does not fit the selected format are consumed,
// produce no word, and raise a one-cycle err_range pulse.
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   request present
//   req_ready  out  request accepted this cycle (IDLE, nothing pending)
//   req_fmt    in   0=R 1=I 2=I-shift 3=S 4=B 5=U 6=J 7=LI
//   req_opcode in   opcode (ignored for LI)
//   req_funct3 in   funct3
//   req_funct7 in   funct7 (R and I-shift only)
//   req_rd     in   destination register
//   req_rs1    in   source register 1
//   req_rs2    in   source register 2
//   req_imm    in   immediate, byte value (B/J are byte offsets)
//   inst_valid out  inst_out holds an encoded word
//   inst_ready in   consumer takes inst_out this cycle
//   inst_out   out  encoded instruction word
//   inst_last  out  final word of the current request
//   err_range  out  one-cycle pulse: last accepted request out of range
// -----------------------------------------------------------------------------
module inst_enc (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_fmt,
    input  logic [6:0]  req_opcode,
    input  logic [2:0]  req_funct3,
    input  logic [6:0]  req_funct7,
    input  logic [4:0]  req_rd,
    input  logic [4:0]  req_rs1,
    input  logic [4:0]  req_rs2,
    input  logic [31:0] req_imm,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic        inst_last,
    output logic        err_range
);

    typedef enum logic [1:0] {IDLE, OUT1, OUT2} state_t;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    state_t      state_q;
    logic        ready_q;
    logic        valid_q;
    logic [31:0] out_q;
    logic        last_q;
    logic        err_q;
    logic [31:0] addi_q;   // second LI word, parked until the LUI transfers

    logic [31:0] word1_d;
    logic [31:0] word2_d;
    logic        last1_d;
    logic        ok_d;

    logic        fits12;
    logic [31:0] li_sum;

    // Signed 12-bit fit: every bit above bit 11 is a copy of bit 11.
    assign fits12 = (req_imm[31:11] == {21{req_imm[11]}});
    // Rounding the upper part up compensates for ADDI sign-extending lo.
    assign li_sum = req_imm + 32'h0000_0800;

    always_comb begin
        word1_d = '0;
        word2_d = '0;
        last1_d = 1'b1;
        ok_d    = 1'b1;
        case (req_fmt)
            3'd0: word1_d = {req_funct7, req_rs2, req_rs1, req_funct3, req_rd, req_opcode};
            3'd1: begin
                word1_d = {req_imm[11:0], req_rs1, req_funct3, req_rd, req_opcode};
                ok_d    = fits12;
            end
            3'd2: begin
                word1_d = {req_funct7, req_imm[4:0], req_rs1, req_funct3, req_rd, req_opcode};
                ok_d    = (req_imm[31:5] == '0);
            end
            3'd3: begin
                word1_d = {req_imm[11:5], req_rs2, req_rs1, req_funct3, req_imm[4:0], req_opcode};
                ok_d    = fits12;
            end
            3'd4: begin
                word1_d = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_funct3,
                           req_imm[4:1], req_imm[11], req_opcode};
                ok_d    = (req_imm[31:12] == {20{req_imm[12]}}) && !req_imm[0];
            end
            3'd5: begin
                word1_d = {req_imm[31:12], req_rd, req_opcode};
                ok_d    = (req_imm[11:0] == '0);
            end
            3'd6: begin
                word1_d = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12],
                           req_rd, req_opcode};
                ok_d    = (req_imm[31:20] == {12{req_imm[20]}}) && !req_imm[0];
            end
            default: begin
                // LI: ADDI rd,x0,imm when it fits, else LUI rd,hi [+ ADDI rd,rd,lo]
                if (fits12) begin
                    word1_d = {req_imm[11:0], 5'd0, 3'b000, req_rd, OPC_OP_IMM};
                end else begin
                    word1_d = {li_sum[31:12], req_rd, OPC_LUI};
                    if (req_imm[11:0] != '0) begin
                        last1_d = 1'b0;
                        word2_d = {req_imm[11:0], req_rd, 3'b000, req_rd, OPC_OP_IMM};
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            out_q   <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            addi_q  <= '0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid && ready_q) begin
                        if (ok_d) begin
                            state_q <= OUT1;
                            ready_q <= 1'b0;
                            valid_q <= 1'b1;
                            out_q   <= word1_d;
                            last_q  <= last1_d;
                            addi_q  <= word2_d;
                        end else begin
                            err_q   <= 1'b1;
                        end
                    end else begin
                        // Also raises ready on the first edge out of reset.
                        ready_q <= 1'b1;
                    end
                end
                OUT1: begin
                    if (valid_q && inst_ready) begin
                        if (last_q) begin
                            state_q <= IDLE;
                            valid_q <= 1'b0;
                            ready_q <= 1'b1;
                        end else begin
                            state_q <= OUT2;
                            out_q   <= addi_q;
                            last_q  <= 1'b1;
                        end
                    end
                end
                OUT2: begin
                    if (valid_q && inst_ready) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = ready_q;
    assign inst_valid = valid_q;
    assign inst_out   = out_q;
    assign inst_last  = last_q;
    assign err_range  = err_q;

endmodule

// File: tb/tb_inst_enc.sv
// -----------------------------------------------------------------------------
// tb_inst_enc -- scoreboard bench for inst_enc. Expected words are queued when
// a request is accepted and compared as the encoder hands them over.
// -----------------------------------------------------------------------------
module tb_inst_enc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_fmt = '0;
    logic [6:0]  req_opcode = '0;
    logic [2:0]  req_funct3 = '0;
    logic [6:0]  req_funct7 = '0;
    logic [4:0]  req_rd = '0;
    logic [4:0]  req_rs1 = '0;
    logic [4:0]  req_rs2 = '0;
    logic [31:0] req_imm = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_out;
    logic        inst_last;
    logic        err_range;

    typedef struct {
        logic [31:0] w;
        logic        l;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;
    bit          rnd_rdy = 1'b0;
    bit          force_rdy = 1'b1;
    bit          hold_v = 1'b0;
    logic [31:0] hold_w;
    logic        hold_l;

    int edges[14] = '{0, 31, 32, -1, 2047, 2048, -2048, -2049, 4094, 4096, -4096,
                      1048574, -1048576, 1048576};

    inst_enc dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_fmt    (req_fmt),
        .req_opcode (req_opcode),
        .req_funct3 (req_funct3),
        .req_funct7 (req_funct7),
        .req_rd     (req_rd),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .req_imm    (req_imm),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst_out   (inst_out),
        .inst_last  (inst_last),
        .err_range  (err_range)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [31:0] w, input logic l);
        sb.push_back('{w, l});
    endtask

    // Reference encoder written with shifts and masks on the byte-valued imm.
    function automatic void model(input logic [2:0] fmt, input logic [6:0] opc,
                                  input logic [2:0] f3, input logic [6:0] f7,
                                  input logic [4:0] rd, input logic [4:0] rs1,
                                  input logic [4:0] rs2, input logic [31:0] imm,
                                  output bit ok, output int n,
                                  output logic [31:0] w0, output logic [31:0] w1);
        int          s;
        logic [31:0] o, lo, hi;
        s  = imm;
        o  = 32'(opc);
        ok = 1'b1;
        n  = 1;
        w0 = '0;
        w1 = '0;
        case (fmt)
            3'd0: w0 = (32'(f7) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) |
                       (32'(f3) << 12) | (32'(rd) << 7) | o;
            3'd1: begin
                ok = (s >= -2048) && (s <= 2047);
                w0 = ((imm & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) |
                     (32'(rd) << 7) | o;
            end
            3'd2: begin
                ok = (imm <= 32'd31);
                w0 = (32'(f7) << 25) | ((imm & 32'h1F) << 20) | (32'(rs1) << 15) |
                     (32'(f3) << 12) | (32'(rd) << 7) | o;
            end
            3'd3: begin
                ok = (s >= -2048) && (s <= 2047);
                w0 = (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) |
                     (32'(f3) << 12) | ((imm & 32'h1F) << 7) | o;
            end
            3'd4: begin
                ok = (s >= -4096) && (s <= 4094) && (imm[0] == 1'b0);
                w0 = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) |
                     (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) |
                     (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7) | o;
            end
            3'd5: begin
                ok = ((imm & 32'hFFF) == 0);
                w0 = (imm & 32'hFFFF_F000) | (32'(rd) << 7) | o;
            end
            3'd6: begin
                ok = (s >= -1048576) && (s <= 1048574) && (imm[0] == 1'b0);
                w0 = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
                     (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12) |
                     (32'(rd) << 7) | o;
            end
            default: begin
                if ((s >= -2048) && (s <= 2047)) begin
                    w0 = ((imm & 32'hFFF) << 20) | (32'(rd) << 7) | 32'h13;
                end else begin
                    lo = imm & 32'hFFF;
                    hi = (imm + 32'h800) & 32'hFFFF_F000;
                    w0 = hi | (32'(rd) << 7) | 32'h37;
                    if (lo != 0) begin
                        n  = 2;
                        w1 = (lo << 20) | (32'(rd) << 15) | (32'(rd) << 7) | 32'h13;
                    end
                end
            end
        endcase
    endfunction

    // Drive one request (called on a falling edge) and check the accept response.
    task automatic issue(input logic [2:0] fmt, input logic [6:0] opc, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [31:0] imm, input bit ok);
        int n = 0;
        req_valid  = 1'b1;
        req_fmt    = fmt;
        req_opcode = opc;
        req_funct3 = f3;
        req_funct7 = f7;
        req_rd     = rd;
        req_rs1    = rs1;
        req_rs2    = rs2;
        req_imm    = imm;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("req_ready_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        // Scramble inputs after acceptance; pending output must not follow them.
        req_valid  = 1'b0;
        req_fmt    = 3'($urandom);
        req_opcode = 7'($urandom);
        req_funct3 = 3'($urandom);
        req_funct7 = 7'($urandom);
        req_rd     = 5'($urandom);
        req_rs1    = 5'($urandom);
        req_rs2    = 5'($urandom);
        req_imm    = $urandom;
        @(negedge clk);
        chk("lat_valid", 32'(inst_valid), 32'(ok));
        chk("err_pulse", 32'(err_range), 32'(!ok));
        if (!ok) begin
            @(negedge clk);
            chk("err_width", 32'(err_range), 32'd0);
            chk("err_novalid", 32'(inst_valid), 32'd0);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(sb.size()), 32'd0);
    endtask

    always @(posedge clk) begin
        #1;
        if (rnd_rdy) inst_ready = ($urandom_range(3) != 0);
        else         inst_ready = force_rdy;
    end

    // Output monitor: compares each transferred word, checks stability under stall.
    always @(negedge clk) begin
        exp_t e;
        if (!mon_en) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                chk("hold_valid", 32'(inst_valid), 32'd1);
                chk("hold_word", inst_out, hold_w);
                chk("hold_last", 32'(inst_last), 32'(hold_l));
            end
            hold_v = 1'b0;
            if (inst_valid) begin
                if (inst_ready) begin
                    if (sb.size() == 0) begin
                        chk("sb_underflow", inst_out, 32'hxxxx_xxxx);
                    end else begin
                        e = sb.pop_front();
                        chk("word", inst_out, e.w);
                        chk("last", 32'(inst_last), 32'(e.l));
                    end
                end else begin
                    hold_v = 1'b1;
                    hold_w = inst_out;
                    hold_l = inst_last;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit          ok;
        int          n;
        logic [31:0] w0, w1, imm;
        logic [2:0]  fmt;
        logic [6:0]  opc, f7;
        logic [2:0]  f3;
        logic [4:0]  rd, rs1, rs2;

        // Reset state
        @(negedge clk);
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_out", inst_out, 32'd0);
        chk("rst_last", 32'(inst_last), 32'd0);
        chk("rst_err", 32'(err_range), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1 chk("ready_pre_edge", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("ready_first_edge", 32'(req_ready), 32'd1);
        mon_en = 1'b1;

        // B branch, offset 8
        push(32'h0020_8463, 1'b1);
        issue(3'd4, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b1);
        drain();

        // J in range, then odd offset
        push(32'h0010_00EF, 1'b1);
        issue(3'd6, 7'b1101111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h800, 1'b1);
        drain();
        issue(3'd6, 7'b1101111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd3, 1'b0);
        @(negedge clk);
        chk("err_no_word", 32'(inst_valid), 32'd0);

        // LI two words, first word stalled three cycles
        force_rdy = 1'b0;
        push(32'h1234_62B7, 1'b0);
        push(32'hFFF2_8293, 1'b1);
        issue(3'd7, 7'd0, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5FFF, 1'b1);
        repeat (2) @(negedge clk);
        force_rdy = 1'b1;
        drain();

        // LI single-word cases
        push(32'h0000_12B7, 1'b1);
        issue(3'd7, 7'd0, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h0000_1000, 1'b1);
        push(32'hFFB0_0513, 1'b1);
        issue(3'd7, 7'd0, 3'd0, 7'd0, 5'd10, 5'd0, 5'd0, 32'hFFFF_FFFB, 1'b1);
        drain();

        // Reset while the LUI is pending with its ADDI parked
        force_rdy = 1'b0;
        issue(3'd7, 7'd0, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5FFF, 1'b1);
        mon_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(inst_valid), 32'd0);
        chk("mid_rst_out", inst_out, 32'd0);
        chk("mid_rst_last", 32'(inst_last), 32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        force_rdy = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        chk("rel_ready", 32'(req_ready), 32'd1);
        chk("rel_valid", 32'(inst_valid), 32'd0);
        repeat (3) @(negedge clk);
        chk("rel_no_word", 32'(inst_valid), 32'd0);

        // Random requests with random output backpressure
        rnd_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            fmt = 3'($urandom);
            opc = 7'($urandom);
            f3  = 3'($urandom);
            f7  = 7'($urandom);
            rd  = 5'($urandom);
            rs1 = 5'($urandom);
            rs2 = 5'($urandom);
            case ($urandom_range(3))
                0:       imm = $urandom;
                1:       imm = 32'($urandom_range(10000)) - 32'd5000;
                default: imm = 32'(edges[$urandom_range(13)]) + 32'($urandom_range(2)) - 32'd1;
            endcase
            if ($urandom_range(3) == 0) imm[11:0] = '0;
            model(fmt, opc, f3, f7, rd, rs1, rs2, imm, ok, n, w0, w1);
            if (ok) begin
                push(w0, (n == 1));
                if (n == 2) push(w1, 1'b1);
            end
            issue(fmt, opc, f3, f7, rd, rs1, rs2, imm, ok);
        end
        rnd_rdy = 1'b0;
        force_rdy = 1'b1;
        drain();
        repeat (3) @(negedge clk);
        chk("final_idle", 32'(inst_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
